// File: rtl/boot_loader.sv
// boot_loader: receives a framed byte stream (length, data, checksum) over a
// valid/ready handshake and writes it into program RAM from address 0, holding
// the CPU in boot until an image with a matching checksum has been loaded.
module boot_loader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              start,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              boot,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic              done,
  output logic              error
);

  // Counter and length need one extra bit so a full 2^ADDR_W image is representable.
  localparam int CW = ADDR_W + 1;
  // Width wide enough to compare the raw length byte against 2^ADDR_W.
  localparam int LW = (DATA_W > CW) ? DATA_W : CW;
  localparam logic [LW-1:0] MAX_LEN = LW'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_boot;
  logic              r_done;
  logic              r_error;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     r_len;
  logic [DATA_W-1:0] r_sum;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_data;

  logic              w_xfer;
  logic [CW-1:0]     w_count_inc;
  logic [LW-1:0]     w_len_wide;
  logic              w_len_bad;

  assign w_xfer      = rx_valid & rx_ready;
  assign w_count_inc = r_count + CW'(1);
  assign w_len_wide  = LW'(rx_data);
  assign w_len_bad   = (w_len_wide == '0) || (w_len_wide > MAX_LEN);

  assign boot     = r_boot;
  assign done     = r_done;
  assign error    = r_error;
  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;

  // State register plus registered status flags that follow the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_LEN;
      r_boot  <= 1'b1;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else if (ce) begin
      r_state <= w_next;
      r_boot  <= (w_next != S_DONE);
      r_done  <= (w_next == S_DONE);
      r_error <= (w_next == S_ERR);
    end
  end

  // Next-state decode with handshake and memory strobes; everything is gated by ce.
  always_comb begin
    w_next   = r_state;
    rx_ready = 1'b0;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    case (r_state)
      S_LEN: begin
        rx_ready = ce;
        if (w_xfer) w_next = w_len_bad ? S_ERR : S_DATA;
      end
      S_DATA: begin
        rx_ready = ce;
        if (w_xfer) w_next = S_WRITE;
      end
      S_WRITE: begin
        mem_en = ce;
        mem_we = ce;
        if (ce) w_next = (w_count_inc == r_len) ? S_CHK : S_DATA;
      end
      S_CHK: begin
        rx_ready = ce;
        if (w_xfer) w_next = (rx_data == r_sum) ? S_DONE : S_ERR;
      end
      S_DONE: begin
        if (ce && start) w_next = S_LEN;
      end
      S_ERR: begin
        if (ce && start) w_next = S_LEN;
      end
      default: w_next = S_LEN;
    endcase
  end

  // Frame datapath: captured length, write counter, running checksum, write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count    <= '0;
      r_len      <= '0;
      r_sum      <= '0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else if (ce) begin
      case (r_state)
        S_LEN: begin
          if (w_xfer) begin
            r_len   <= CW'(rx_data);
            r_count <= '0;
            r_sum   <= '0;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_mem_data <= rx_data;
            r_mem_addr <= r_count[ADDR_W-1:0];
            r_sum      <= r_sum + rx_data;
          end
        end
        S_WRITE: begin
          r_count <= w_count_inc;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed frames through boot_loader with a write scoreboard.
module tb_boot_loader;

  localparam int AW = 6;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic          start;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          boot;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_en;
  logic          mem_we;
  logic          done;
  logic          error;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] frame_q[$];
  logic [7:0] tb_mem[64];
  int         n_vec = 0;
  int         n_err = 0;
  int         n_writes = 0;
  int         w0;
  bit         stall_on = 1'b0;
  bit         gaps_on = 1'b0;

  always #5 clk = ~clk;

  boot_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .ce(ce), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .boot(boot), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_en(mem_en), .mem_we(mem_we), .done(done), .error(error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one byte and wait (bounded) until the handshake completes.
  task automatic send_byte(input logic [7:0] b, input bit st);
    int gap;
    int guard;
    gap = gaps_on ? int'($urandom_range(0, 2)) : 0;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    start    = st;
    guard    = 0;
    #1;
    while (!(rx_ready && ce) && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check("xfer_not_timed_out", guard < 200, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Length byte, contents of frame_q (scoreboarded), checksum byte.
  task automatic send_frame(input logic [7:0] len_b, input logic [7:0] chk, input bit st);
    wr_t e;
    send_byte(len_b, 1'b0);
    for (int i = 0; i < frame_q.size(); i++) begin
      e.a = i[AW-1:0];
      e.d = frame_q[i];
      exp_q.push_back(e);
      send_byte(frame_q[i], st && (i == 1));
    end
    send_byte(chk, st);
    #1;
  endtask

  task automatic rearm();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  task automatic load_nominal();
    frame_q.delete();
    frame_q.push_back(8'h11);
    frame_q.push_back(8'h22);
    frame_q.push_back(8'h33);
  endtask

  // Clock-enable generator: random ce=0 cycles while stalling is enabled.
  initial begin
    ce = 1'b1;
    forever begin
      @(negedge clk);
      ce = stall_on ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Write monitor: each mem_we cycle must match the next scoreboard entry.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      #2;
      if (mem_we || !ce) check("we_while_ce0", mem_we & ~ce, 1'b0);
      if (mem_we) begin
        n_writes++;
        check("we_en_pair", mem_en, 1'b1);
        check("ready_in_write", rx_ready, 1'b0);
        check("write_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_addr", mem_addr, e.a);
          check("wr_data", mem_data, e.d);
        end
        tb_mem[mem_addr] = mem_data;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = '0;
    #2 rst = 1'b0;
    #1;
    check("rst_boot", boot, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_data", mem_data, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_ready_len", rx_ready, 1'b1);

    // Nominal load
    w0 = n_writes;
    load_nominal();
    send_frame(8'h03, 8'h66, 1'b0);
    check("nom_done", done, 1'b1);
    check("nom_boot", boot, 1'b0);
    check("nom_error", error, 1'b0);
    check("nom_ready_idle", rx_ready, 1'b0);
    check("nom_writes", n_writes - w0, 3);
    check("nom_q_empty", exp_q.size(), 0);
    rearm();
    check("rearm_boot", boot, 1'b1);
    check("rearm_done", done, 1'b0);
    check("rearm_ready", rx_ready, 1'b1);

    // Bad checksum
    w0 = n_writes;
    frame_q.delete(); frame_q.push_back(8'hFF); frame_q.push_back(8'h02);
    send_frame(8'h02, 8'h00, 1'b0);
    check("badchk_error", error, 1'b1);
    check("badchk_boot", boot, 1'b1);
    check("badchk_done", done, 1'b0);
    check("badchk_writes", n_writes - w0, 2);
    rearm();
    check("err_clear", error, 1'b0);
    check("err_rearm_ready", rx_ready, 1'b1);
    load_nominal();
    send_frame(8'h03, 8'h66, 1'b0);
    check("after_err_done", done, 1'b1);
    rearm();

    // Length zero
    w0 = n_writes;
    send_byte(8'h00, 1'b0);
    #1;
    check("len0_error", error, 1'b1);
    check("len0_boot", boot, 1'b1);
    repeat (3) @(negedge clk);
    check("len0_no_write", n_writes - w0, 0);
    rearm();

    // Length too large
    w0 = n_writes;
    send_byte(8'h41, 1'b0);
    #1;
    check("len41_error", error, 1'b1);
    repeat (3) @(negedge clk);
    check("len41_no_write", n_writes - w0, 0);
    rearm();

    // Full-capacity image
    w0 = n_writes;
    frame_q.delete();
    for (int i = 0; i < 64; i++) frame_q.push_back(8'h01);
    send_frame(8'h40, 8'h40, 1'b0);
    check("len40_done", done, 1'b1);
    check("len40_writes", n_writes - w0, 64);
    check("len40_last_addr", mem_addr, 6'h3F);
    rearm();

    // ce stalls and rx_valid gaps
    w0 = n_writes;
    tb_mem[0] = '0; tb_mem[1] = '0; tb_mem[2] = '0;
    stall_on = 1'b1; gaps_on = 1'b1;
    load_nominal();
    send_frame(8'h03, 8'h66, 1'b0);
    stall_on = 1'b0; gaps_on = 1'b0;
    check("stall_done", done, 1'b1);
    check("stall_writes", n_writes - w0, 3);
    check("stall_mem0", tb_mem[0], 8'h11);
    check("stall_mem1", tb_mem[1], 8'h22);
    check("stall_mem2", tb_mem[2], 8'h33);
    @(negedge clk);
    #1;
    rearm();

    // Reset mid-frame after two of three data bytes
    wr_t_push: begin
      wr_t e;
      send_byte(8'h03, 1'b0);
      e.a = 6'd0; e.d = 8'hA1; exp_q.push_back(e);
      send_byte(8'hA1, 1'b0);
      e.a = 6'd1; e.d = 8'hA2; exp_q.push_back(e);
      send_byte(8'hA2, 1'b0);
    end
    @(negedge clk);
    #3 rst = 1'b0;
    #1;
    check("midrst_boot", boot, 1'b1);
    check("midrst_ready_len", rx_ready, 1'b1);
    check("midrst_mem_we", mem_we, 1'b0);
    check("midrst_addr", mem_addr, 0);
    check("midrst_q_empty", exp_q.size(), 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    w0 = n_writes;
    load_nominal();
    send_frame(8'h03, 8'h66, 1'b0);
    check("postrst_done", done, 1'b1);
    check("postrst_writes", n_writes - w0, 3);
    check("postrst_mem0", tb_mem[0], 8'h11);
    rearm();

    // start held during DATA and CHK is ignored
    w0 = n_writes;
    load_nominal();
    send_frame(8'h03, 8'h66, 1'b1);
    check("startign_done", done, 1'b1);
    check("startign_boot", boot, 1'b0);
    check("startign_writes", n_writes - w0, 3);
    repeat (2) @(negedge clk);
    #1;
    check("startign_stays_done", done, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
